i2c_slave_responder: RTL and testbench

- Synthesizable I2C target (responder) answering the I2CMB master on the shared SCL/SDA bus.
- Oversamples SCL/SDA in the system clock domain and detects START, repeated START and STOP.
- Matches a 7-bit address, ACKs written bytes and serves read bytes from a local byte interface.
- Used as an RTL bus partner in integration benches alongside, or instead of, the behavioural I2C agent.

---
 rtl/i2c_slave_responder.sv | 193 +++++++++++++++++++
 tb/tb_i2c_slave_responder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_responder.sv
// I2C target: oversampled/filtered SCL+SDA, START/STOP detect, 7-bit address match, write ACK, read serving.
// Optional clock stretching while waiting for read data: define I2C_SLAVE_CLK_STRETCH_EN.
module i2c_slave_responder #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h22,
  parameter int         SYNC_STAGES = 2,
  parameter int         FILTER_LEN  = 3
) (
  input  logic       clk_i,
  input  logic       arst_n_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic       scl_oe_o,
  output logic       start_o,
  output logic       stop_o,
  output logic       addr_match_o,
  output logic       rw_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       tx_req_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       nack_o
);
  localparam logic [2:0] IDLE = 3'd0, ADDR = 3'd1, IGNORE = 3'd2, ADDR_ACK = 3'd3,
                         WR_DATA = 3'd4, WR_ACK = 3'd5, RD_DATA = 3'd6, RD_ACK = 3'd7;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic [FILTER_LEN-1:0]  scl_hist, sda_hist;
  logic                   scl_f, sda_f, scl_d, sda_d;

  // Everything presets high so the bus looks idle straight out of reset.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      scl_sync <= '1; sda_sync <= '1;
      scl_hist <= '1; sda_hist <= '1;
      scl_f <= 1'b1; sda_f <= 1'b1; scl_d <= 1'b1; sda_d <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_hist <= {scl_hist[FILTER_LEN-2:0], scl_sync[SYNC_STAGES-1]};
      sda_hist <= {sda_hist[FILTER_LEN-2:0], sda_sync[SYNC_STAGES-1]};
      if (&scl_hist) scl_f <= 1'b1; else if (~|scl_hist) scl_f <= 1'b0;
      if (&sda_hist) sda_f <= 1'b1; else if (~|sda_hist) sda_f <= 1'b0;
      scl_d <= scl_f;
      sda_d <= sda_f;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_f & ~scl_d;
  assign scl_fall  = ~scl_f & scl_d;
  assign start_det = scl_f & ~sda_f & sda_d;
  assign stop_det  = scl_f & sda_f & ~sda_d;

  logic [2:0] state, cnt;
  logic [6:0] sr;
  logic [7:0] tx_buf, next_byte, byte_in;
  logic       pend, lead, lead_fall;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
  logic       stretch, relq;
`endif

  assign byte_in   = {sr, sda_f};
  assign next_byte = (pend && tx_valid_i) ? tx_data_i : tx_buf;
  // The fall that starts bit 7 of a read byte: end of address ACK, or first fall after a master ACK.
  assign lead_fall = scl_fall && ((state == ADDR_ACK && sda_oe_o && rw_o) || (state == RD_DATA && lead));

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state <= IDLE; cnt <= '0; sr <= '0; tx_buf <= '0; pend <= 1'b0; lead <= 1'b0;
      sda_oe_o <= 1'b0; start_o <= 1'b0; stop_o <= 1'b0; addr_match_o <= 1'b0; rw_o <= 1'b0;
      rx_data_o <= '0; rx_valid_o <= 1'b0; tx_req_o <= 1'b0; nack_o <= 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
      scl_oe_o <= 1'b0; stretch <= 1'b0; relq <= 1'b0;
`endif
    end else begin
      start_o <= 1'b0; stop_o <= 1'b0; rx_valid_o <= 1'b0; tx_req_o <= 1'b0; nack_o <= 1'b0;
      if (pend && tx_valid_i) begin
        tx_buf <= tx_data_i;
        pend   <= 1'b0;
      end
      if (start_det || stop_det) begin
        start_o      <= start_det;
        stop_o       <= stop_det;
        state        <= start_det ? ADDR : IDLE;
        cnt          <= '0;
        addr_match_o <= 1'b0;
        sda_oe_o     <= 1'b0;
        pend         <= 1'b0;
        lead         <= 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
        scl_oe_o <= 1'b0; stretch <= 1'b0; relq <= 1'b0;
`endif
      end else begin
        case (state)
          ADDR: if (scl_rise) begin
            sr  <= byte_in[6:0];
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              if (byte_in[7:1] == SLAVE_ADDR) begin
                rw_o         <= byte_in[0];
                addr_match_o <= 1'b1;
                state        <= ADDR_ACK;
                if (byte_in[0]) begin
                  tx_req_o <= 1'b1;
                  pend     <= 1'b1;
                end
              end else begin
                state <= IGNORE;
              end
            end
          end
          ADDR_ACK, WR_ACK: if (scl_fall) begin
            // sda_oe_o doubles as the ACK phase: low before the 8th fall, high until the 9th.
            if (!sda_oe_o) sda_oe_o <= 1'b1;
            else if (lead_fall) state <= RD_DATA;
            else begin
              sda_oe_o <= 1'b0;
              state    <= WR_DATA;
            end
          end
          WR_DATA: if (scl_rise) begin
            sr  <= byte_in[6:0];
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              rx_data_o  <= byte_in;
              rx_valid_o <= 1'b1;
              state      <= WR_ACK;
            end
          end
          RD_DATA: begin
            if (scl_rise) cnt <= cnt + 3'd1;
            else if (scl_fall && !lead) begin
              if (cnt == 3'd0) begin
                sda_oe_o <= 1'b0;
                state    <= RD_ACK;
              end else begin
                sda_oe_o <= ~tx_buf[~cnt];
              end
            end
          end
          RD_ACK: if (scl_rise) begin
            if (!sda_f) begin
              tx_req_o <= 1'b1;
              pend     <= 1'b1;
              lead     <= 1'b1;
              state    <= RD_DATA;
            end else begin
              nack_o <= 1'b1;
              state  <= IGNORE;
            end
          end
          default: ;
        endcase

        if (lead_fall) begin
          lead <= 1'b0;
          if (pend && !tx_valid_i) begin
`ifdef I2C_SLAVE_CLK_STRETCH_EN
            sda_oe_o <= 1'b0;
            scl_oe_o <= 1'b1;
            stretch  <= 1'b1;
`else
            tx_buf   <= 8'hFF;
            pend     <= 1'b0;
            sda_oe_o <= 1'b0;
`endif
          end else begin
            sda_oe_o <= ~next_byte[7];
          end
        end

`ifdef I2C_SLAVE_CLK_STRETCH_EN
        // Put bit 7 on SDA first, let SCL go one cycle later.
        if (stretch && pend && tx_valid_i) begin
          sda_oe_o <= ~tx_data_i[7];
          stretch  <= 1'b0;
          relq     <= 1'b1;
        end
        if (relq) begin
          scl_oe_o <= 1'b0;
          relq     <= 1'b0;
        end
`endif
      end
    end
  end

`ifndef I2C_SLAVE_CLK_STRETCH_EN
  assign scl_oe_o = 1'b0;
`endif
endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench for i2c_slave_responder: open-drain bus model, bit-banged master, event scoreboard.
module tb_i2c_slave_responder;
  localparam int HALF = 20;
  localparam logic [2:0] K_START = 3'd0, K_STOP = 3'd1, K_RX = 3'd2, K_TXREQ = 3'd3, K_NACK = 3'd4;

  typedef struct packed {
    logic [2:0] kind;
    logic [7:0] data;
    logic [1:0] aux;
  } ev_t;

  logic clk = 1'b0, arst_n = 1'b0, scl_m = 1'b1, sda_m = 1'b1;
  logic scl_bus, sda_bus, sda_oe, scl_oe, start, stop, addr_match, rw;
  logic rx_valid, tx_req, tx_valid = 1'b0, nack;
  logic [7:0] rx_data, tx_data = 8'h00;

  assign scl_bus = scl_m & ~scl_oe;
  assign sda_bus = sda_m & ~sda_oe;

  i2c_slave_responder dut (
    .clk_i(clk), .arst_n_i(arst_n), .scl_i(scl_bus), .sda_i(sda_bus),
    .sda_oe_o(sda_oe), .scl_oe_o(scl_oe), .start_o(start), .stop_o(stop),
    .addr_match_o(addr_match), .rw_o(rw), .rx_data_o(rx_data), .rx_valid_o(rx_valid),
    .tx_req_o(tx_req), .tx_data_i(tx_data), .tx_valid_i(tx_valid), .nack_o(nack)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  ev_t exp_q[$];
  logic [7:0] tx_q[$];
  int dly_q[$];
  int start_cnt = 0, stop_cnt = 0;
  logic watch = 1'b0, ign_drive = 1'b0, match_seen = 1'b0, stretch_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic expect_ev(input logic [2:0] k, input logic [7:0] d, input logic [1:0] a);
    ev_t e;
    e.kind = k; e.data = d; e.aux = a;
    exp_q.push_back(e);
  endtask

  task automatic got(input logic [2:0] k, input logic [7:0] d, input logic [1:0] a);
    ev_t e, g;
    g.kind = k; g.data = d; g.aux = a;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_event: got %0h, expected none", g);
    end else begin
      e = exp_q.pop_front();
      check("event", g, e);
    end
  endtask

  // Monitor: every output pulse is popped against the scoreboard.
  initial forever begin
    @(negedge clk);
    if (arst_n) begin
      if (start)    begin start_cnt++; got(K_START, 8'h00, {addr_match, sda_oe | scl_oe}); end
      if (stop)     begin stop_cnt++;  got(K_STOP,  8'h00, {addr_match, sda_oe | scl_oe}); end
      if (rx_valid) got(K_RX,    rx_data, {addr_match, rw});
      if (tx_req)   got(K_TXREQ, 8'h00,   {addr_match, rw});
      if (nack)     got(K_NACK,  8'h00,   {addr_match, sda_oe});
      if (watch && sda_oe)     ign_drive = 1'b1;
      if (watch && addr_match) match_seen = 1'b1;
      if (scl_oe === 1'b1)     stretch_seen = 1'b1;
    end
  end

  // Local byte source: answers each tx_req after a per-request delay.
  logic [7:0] rsp_v;
  int rsp_d;
  initial forever begin
    @(negedge clk);
    if (tx_req) begin
      rsp_v = (tx_q.size() != 0) ? tx_q.pop_front() : 8'h00;
      rsp_d = (dly_q.size() != 0) ? dly_q.pop_front() : 2;
      repeat (rsp_d) @(posedge clk);
      #1 tx_data = rsp_v; tx_valid = 1'b1;
      @(posedge clk);
      #1 tx_valid = 1'b0;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scl_rel();
    int n;
    n = 0;
    scl_m = 1'b1;
    while (scl_bus !== 1'b1 && n < 3000) begin @(posedge clk); n++; end
    #1;
    if (scl_bus !== 1'b1) begin
      checks++; errors++;
      $display("FAIL scl_release_timeout: got scl=%0b, expected 1", scl_bus);
    end
  endtask

  task automatic clk_bit(input logic b, output logic s);
    sda_m = b; cyc(HALF);
    scl_rel(); cyc(HALF / 2);
    s = sda_bus; cyc(HALF / 2);
    scl_m = 1'b0; cyc(4);
  endtask

  task automatic m_start();
    sda_m = 1'b1; cyc(HALF);
    scl_rel(); cyc(HALF);
    sda_m = 1'b0; cyc(HALF);
    scl_m = 1'b0; cyc(4);
  endtask

  task automatic m_stop();
    sda_m = 1'b0; cyc(HALF);
    scl_rel(); cyc(HALF);
    sda_m = 1'b1; cyc(HALF);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    clk_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic s;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin clk_bit(1'b1, s); d = {d[6:0], s}; end
    clk_bit(~mack, s);
  endtask

  logic ack;
  logic [7:0] rd;

  initial begin
    cyc(5);
    check("reset_outputs", {sda_oe, scl_oe, start, stop, addr_match, rw, rx_data, rx_valid, tx_req, nack}, 0);
    arst_n = 1'b1; cyc(10);

    // Write 0x22/W, 0xA5, 0x3C
    expect_ev(K_START, 8'h00, 2'b00); expect_ev(K_RX, 8'hA5, 2'b10);
    expect_ev(K_RX, 8'h3C, 2'b10);    expect_ev(K_STOP, 8'h00, 2'b00);
    m_start();
    write_byte(8'h44, ack); check("w_addr_ack", ack, 1);
    write_byte(8'hA5, ack); check("w_byte0_ack", ack, 1);
    write_byte(8'h3C, ack); check("w_byte1_ack", ack, 1);
    m_stop(); cyc(10);
    check("idle_after_write", {sda_oe, scl_oe, start, stop, addr_match, rw, rx_valid, tx_req, nack}, 0);
    check("rx_data_hold", rx_data, 8'h3C);

    // Foreign address 0x23/W is ignored
    expect_ev(K_START, 8'h00, 2'b00); expect_ev(K_STOP, 8'h00, 2'b00);
    watch = 1'b1;
    m_start();
    write_byte(8'h46, ack); check("foreign_addr_nack", ack, 0);
    write_byte(8'h55, ack); check("foreign_byte_nack", ack, 0);
    m_stop(); cyc(10);
    watch = 1'b0;
    check("foreign_sda_driven", ign_drive, 0);
    check("foreign_addr_match", match_seen, 0);
    expect_ev(K_START, 8'h00, 2'b00); expect_ev(K_RX, 8'h01, 2'b10); expect_ev(K_STOP, 8'h00, 2'b00);
    m_start();
    write_byte(8'h44, ack); check("after_foreign_ack", ack, 1);
    write_byte(8'h01, ack); check("after_foreign_byte_ack", ack, 1);
    m_stop(); cyc(10);

    // Read 0x22/R: 0x96 (ACK), 0x0F (NACK)
    tx_q.push_back(8'h96); dly_q.push_back(2);
    tx_q.push_back(8'h0F); dly_q.push_back(2);
    expect_ev(K_START, 8'h00, 2'b00); expect_ev(K_TXREQ, 8'h00, 2'b11);
    expect_ev(K_TXREQ, 8'h00, 2'b11); expect_ev(K_NACK, 8'h00, 2'b10);
    expect_ev(K_STOP, 8'h00, 2'b00);
    m_start();
    write_byte(8'h45, ack); check("r_addr_ack", ack, 1);
    read_byte(1'b1, rd); check("r_byte0", rd, 8'h96);
    read_byte(1'b0, rd); check("r_byte1", rd, 8'h0F);
    check("sda_released_after_nack", sda_oe, 0);
    m_stop(); cyc(10);

    // Write then repeated START into a read
    tx_q.push_back(8'h77); dly_q.push_back(3);
    expect_ev(K_START, 8'h00, 2'b00); expect_ev(K_RX, 8'h11, 2'b10);
    expect_ev(K_START, 8'h00, 2'b00); expect_ev(K_TXREQ, 8'h00, 2'b11);
    expect_ev(K_NACK, 8'h00, 2'b10);  expect_ev(K_STOP, 8'h00, 2'b00);
    m_start();
    write_byte(8'h44, ack); check("sr_waddr_ack", ack, 1);
    write_byte(8'h11, ack); check("sr_wbyte_ack", ack, 1);
    m_start();
    write_byte(8'h45, ack); check("sr_raddr_ack", ack, 1);
    read_byte(1'b0, rd); check("sr_rbyte", rd, 8'h77);
    m_stop(); cyc(10);

    // Read data withheld well past the bit-7 fall
    tx_q.push_back(8'h5A); dly_q.push_back(150);
    expect_ev(K_START, 8'h00, 2'b00); expect_ev(K_TXREQ, 8'h00, 2'b11);
    expect_ev(K_NACK, 8'h00, 2'b10);  expect_ev(K_STOP, 8'h00, 2'b00);
    m_start();
    write_byte(8'h45, ack); check("late_addr_ack", ack, 1);
    read_byte(1'b0, rd);
`ifdef I2C_SLAVE_CLK_STRETCH_EN
    check("late_byte", rd, 8'h5A);
    check("late_stretched", stretch_seen, 1);
`else
    check("late_byte", rd, 8'hFF);
    check("late_stretched", stretch_seen, 0);
`endif
    m_stop(); cyc(200);

    // One-cycle SDA glitch with SCL high must not look like START/STOP
    begin
      int s0, p0;
      s0 = start_cnt; p0 = stop_cnt;
      sda_m = 1'b0; cyc(1); sda_m = 1'b1; cyc(20);
      check("glitch_start", start_cnt, s0);
      check("glitch_stop", stop_cnt, p0);
    end

    // Reset in the middle of a read byte (all-zero data keeps SDA driven)
    tx_q.push_back(8'h00); dly_q.push_back(2);
    expect_ev(K_START, 8'h00, 2'b00); expect_ev(K_TXREQ, 8'h00, 2'b11);
    m_start();
    write_byte(8'h45, ack); check("rst_addr_ack", ack, 1);
    for (int i = 0; i < 3; i++) begin
      logic s;
      clk_bit(1'b1, s);
    end
    cyc(6);
    check("rst_pre_sda_oe", sda_oe, 1);
    #2 arst_n = 1'b0;
    #1 check("rst_lines_released", {sda_oe, scl_oe}, 0);
    scl_m = 1'b1; sda_m = 1'b1;
    cyc(5); arst_n = 1'b1; cyc(20);

    check("scoreboard_left", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
